bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter. Sits directly upstream of the 4-digit seven-segment display driver.
- Takes a binary value from the CPU datapath (register/ALU result) and converts it with iterative shift-add-3 (double dabble).
- Holds a stable 16-bit packed-BCD word (4 nibbles, MS digit in [15:12]) that drives the display driver's 16-bit input directly.
- Flags values that do not fit in 4 decimal digits.

---
 rtl/bin2bcd_seq.sv | 112 +++++++++++
 tb/tb_bin2bcd_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 (double dabble) binary to packed-BCD
// converter. The result register is updated only when a conversion
// finishes, so a downstream display never sees intermediate digits.
module bin2bcd_seq #(
    parameter int          IN_W       = 16,
    parameter logic [3:0]  OVF_NIBBLE = 4'hE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [15:0]     bcd,
    output logic            ovf
);

    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IN_W-1:0] shreg_q, shreg_d;
    logic [19:0]     acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [19:0]     acc_adj;
    logic [19:0]     acc_sh;

    // Add-3 correction on every accumulator digit, then shift in the next bit.
    always_comb begin
        acc_adj = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                          : acc_q[4*i +: 4];
        end
        acc_sh = {acc_adj[18:0], shreg_q[IN_W-1]};
    end

    // Next-state and datapath control for the IDLE/SHIFT sequencer.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = bin;
                    acc_d   = '0;
                    cnt_d   = CW'(IN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = acc_sh;
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    // Digits are valid BCD, so exceeding 9999 shows up only as a
                    // nonzero fifth digit.
                    if (acc_sh[19:16] != 4'd0) begin
                        ovf_d = 1'b1;
                        bcd_d = {4{OVF_NIBBLE}};
                    end else begin
                        ovf_d = 1'b0;
                        bcd_d = acc_sh[15:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq at IN_W=16 and IN_W=8.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit instance
    logic        rst16, start16, busy16, done16, ovf16;
    logic [15:0] bin16, bcd16;
    // 8-bit instance
    logic        rst8, start8, busy8, done8, ovf8;
    logic [7:0]  bin8;
    logic [15:0] bcd8;

    bin2bcd_seq #(.IN_W(16), .OVF_NIBBLE(4'hE)) dut16 (
        .clk(clk), .reset(rst16), .start(start16), .bin(bin16),
        .busy(busy16), .done(done16), .bcd(bcd16), .ovf(ovf16)
    );

    bin2bcd_seq #(.IN_W(8), .OVF_NIBBLE(4'hE)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
        int          dn;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] hb16 = '0, hb8 = '0;
    logic        ho16 = 1'b0, ho8 = 1'b0;
    logic        fin8 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: decimal digits by plain division; values above 9999 show EEEE.
    function automatic exp_t model(input int v, input int acc_cyc, input int w);
        exp_t e;
        e.acc = acc_cyc;
        e.dn  = acc_cyc + w;
        if (v > 9999) begin
            e.bcd = 16'hEEEE;
            e.ovf = 1'b1;
        end else begin
            e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; a request is accepted on the next edge if idle.
    task automatic drive16(input int v);
        start16 = 1'b1;
        bin16   = 16'(v);
        if (!busy16 && !rst16) q16.push_back(model(v, cyc + 1, 16));
    endtask

    task automatic wait_idle16();
        for (int i = 0; i < 40 && (busy16 || q16.size() > 0); i++) tick();
        if (busy16 || q16.size() > 0) chk("idle16_timeout", 32'(q16.size()), 0);
    endtask

    task automatic conv16(input int v);
        drive16(v);
        tick();
        start16 = 1'b0;
        bin16   = 16'($urandom);
        wait_idle16();
    endtask

    task automatic conv8(input int v);
        start8 = 1'b1;
        bin8   = 8'(v);
        if (!busy8 && !rst8) q8.push_back(model(v, cyc + 1, 8));
        tick();
        start8 = 1'b0;
        bin8   = 8'($urandom);
        for (int i = 0; i < 30 && (busy8 || q8.size() > 0); i++) tick();
        if (busy8 || q8.size() > 0) chk("idle8_timeout", 32'(q8.size()), 0);
    endtask

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (!rst16) begin
            chk("busy16", 32'(busy16),
                32'(q16.size() > 0 && cyc >= q16[0].acc && cyc < q16[0].dn));
            if (done16) begin
                if (q16.size() == 0) begin
                    chk("done16_unexpected", 32'(done16), 0);
                end else begin
                    exp_t e;
                    e = q16.pop_front();
                    chk("done16_cycle", cyc, e.dn);
                    chk("bcd16", 32'(bcd16), 32'(e.bcd));
                    chk("ovf16", 32'(ovf16), 32'(e.ovf));
                    hb16 = e.bcd;
                    ho16 = e.ovf;
                end
            end else begin
                chk("bcd16_hold", 32'(bcd16), 32'(hb16));
                chk("ovf16_hold", 32'(ovf16), 32'(ho16));
                if (q16.size() > 0 && cyc >= q16[0].dn) begin
                    chk("done16_missing", 32'(done16), 1);
                    void'(q16.pop_front());
                end
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst8) begin
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("done8_unexpected", 32'(done8), 0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("done8_cycle", cyc, e.dn);
                    chk("bcd8", 32'(bcd8), 32'(e.bcd));
                    chk("ovf8", 32'(ovf8), 32'(e.ovf));
                    hb8 = e.bcd;
                    ho8 = e.ovf;
                end
            end else begin
                chk("bcd8_hold", 32'(bcd8), 32'(hb8));
                if (q8.size() > 0 && cyc >= q8[0].dn) begin
                    chk("done8_missing", 32'(done8), 1);
                    void'(q8.pop_front());
                end
            end
        end
    end

    // Stimulus for the 8-bit instance.
    initial begin
        rst8   = 1'b1;
        start8 = 1'b0;
        bin8   = '0;
        repeat (3) tick();
        rst8 = 1'b0;
        conv8(255);
        for (int i = 0; i < 30; i++) conv8(int'($urandom_range(0, 255)));
        fin8 = 1'b1;
    end

    // Stimulus for the 16-bit instance.
    initial begin
        int dlist[8] = '{1234, 0, 9999, 9, 10, 10000, 65535, 42};
        rst16   = 1'b1;
        start16 = 1'b0;
        bin16   = '0;
        repeat (3) tick();
        rst16 = 1'b0;
        chk("rst_busy", 32'(busy16), 0);
        chk("rst_done", 32'(done16), 0);
        chk("rst_bcd",  32'(bcd16),  0);
        chk("rst_ovf",  32'(ovf16),  0);

        foreach (dlist[i]) conv16(dlist[i]);

        // Request while busy is ignored; request in the done cycle is accepted.
        drive16(1234);
        tick();
        start16 = 1'b0;
        repeat (3) tick();
        drive16(5678);
        tick();
        start16 = 1'b0;
        for (int i = 0; i < 40 && !done16; i++) tick();
        drive16(5678);
        tick();
        start16 = 1'b0;
        wait_idle16();

        // Reset mid-conversion aborts with no done pulse.
        conv16(1234);
        drive16(8765);
        tick();
        start16 = 1'b0;
        repeat (6) tick();
        rst16 = 1'b1;
        q16.delete();
        tick();
        rst16 = 1'b0;
        hb16  = '0;
        ho16  = 1'b0;
        chk("abort_busy", 32'(busy16), 0);
        chk("abort_done", 32'(done16), 0);
        chk("abort_bcd",  32'(bcd16),  0);
        chk("abort_ovf",  32'(ovf16),  0);
        conv16(8765);

        // Random start/bin traffic, including starts while busy.
        for (int i = 0; i < 600; i++) begin
            start16 = ($urandom % 4 == 0);
            bin16   = ($urandom % 2 == 1) ? 16'($urandom_range(0, 9999))
                                          : 16'($urandom_range(0, 65535));
            if (start16 && !busy16) q16.push_back(model(int'(bin16), cyc + 1, 16));
            tick();
        end
        start16 = 1'b0;
        wait_idle16();

        for (int i = 0; i < 2000 && !fin8; i++) tick();
        chk("stim8_finished", 32'(fin8), 1);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
